// File: rtl/mac_pkg.sv
// Shared 10G MAC/PCS constants: sync headers, idle block, scrambler seed and taps.
package mac_pkg;

  localparam logic [1:0]  HDR_DATA   = 2'b01;
  localparam logic [1:0]  HDR_CTRL   = 2'b10;
  localparam logic [63:0] IDLE_BLOCK = 64'h0000_0000_0000_001E;
  localparam logic [57:0] SCR_SEED   = 58'h3FF_FFFF_FFFF_FFFF;

  localparam int unsigned SCR_TAP_A = 38;
  localparam int unsigned SCR_TAP_B = 57;

  typedef enum logic {
    PH_LO = 1'b0,
    PH_HI = 1'b1
  } phase_e;

endpackage

// File: rtl/tx_gearbox_feeder_if.sv
// Block stream from the PCS encoder into the TX gearbox feeder.
interface tx_gearbox_feeder_if;

  logic [63:0] tx_data_i;
  logic [1:0]  tx_header_i;
  logic        tx_valid_i;
  logic        tx_ready_o;

  modport master (
    output tx_data_i,
    output tx_header_i,
    output tx_valid_i,
    input  tx_ready_o
  );

  modport slave (
    input  tx_data_i,
    input  tx_header_i,
    input  tx_valid_i,
    output tx_ready_o
  );

endinterface

// File: rtl/scrambler_64b.sv
// Combinational 64-bit parallel x^58+x^39+1 self-synchronous scrambler; bit 0 first.
module scrambler_64b
  import mac_pkg::*;
(
  input  logic [57:0] state_i,
  input  logic [63:0] data_i,
  output logic [57:0] state_o,
  output logic [63:0] data_o
);

  logic [57:0] st;
  logic        b;

  always_comb begin
    st     = state_i;
    b      = 1'b0;
    data_o = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      b         = data_i[i] ^ st[SCR_TAP_A] ^ st[SCR_TAP_B];
      data_o[i] = b;
      st        = {st[56:0], b};
    end
    state_o = st;
  end

endmodule

// File: rtl/tx_gearbox_feeder.sv
// Feeds 66-bit blocks to the GTX TX gearbox (external sequence mode, 32-bit words),
// scrambling payloads, inserting idles on underrun and generating the pause slot.
module tx_gearbox_feeder
  import mac_pkg::*;
#(
  parameter int unsigned P_SEQ_MAX        = 32,
  parameter int unsigned P_UNDERRUN_WIDTH = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  tx_gearbox_feeder_if.slave          tx_if,
  input  logic                        scr_bypass_i,
  output logic [31:0]                 gtwiz_userdata_tx_o,
  output logic [1:0]                  txheader_o,
  output logic [6:0]                  txsequence_o,
  output logic [P_UNDERRUN_WIDTH-1:0] underrun_o
);

  localparam logic [5:0] SEQ_MAX = P_SEQ_MAX[5:0];
  localparam logic [P_UNDERRUN_WIDTH-1:0] UND_ONE = {{(P_UNDERRUN_WIDTH-1){1'b0}}, 1'b1};

  phase_e      phase_q, phase_d;
  logic [5:0]  seq_q, seq_d;
  logic        pause;
  logic        load;

  logic [57:0] scr_st_q, scr_st_d, scr_st_nxt;
  logic [63:0] blk_data, scr_out;
  logic [1:0]  blk_hdr;
  logic [31:0] word_q, word_d;
  logic [31:0] hi_q, hi_d;
  logic [1:0]  hdr_q, hdr_d;
  logic [6:0]  txseq_q, txseq_d;
  logic [P_UNDERRUN_WIDTH-1:0] und_q, und_d;

  // Slot sequencer: state register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      phase_q <= PH_LO;
      seq_q   <= '0;
    end else begin
      phase_q <= phase_d;
      seq_q   <= seq_d;
    end
  end

  // Slot sequencer: next state
  always_comb begin
    phase_d = (phase_q == PH_LO) ? PH_HI : PH_LO;
    seq_d   = seq_q;
    if (phase_q == PH_HI) begin
      seq_d = (seq_q == SEQ_MAX) ? '0 : seq_q + 6'd1;
    end
  end

  // Slot sequencer: outputs
  always_comb begin
    pause            = (seq_q == SEQ_MAX);
    load             = (phase_q == PH_LO) && !pause;
    tx_if.tx_ready_o = load && rst_n_i;
  end

  assign blk_data = tx_if.tx_valid_i ? tx_if.tx_data_i   : IDLE_BLOCK;
  assign blk_hdr  = tx_if.tx_valid_i ? tx_if.tx_header_i : HDR_CTRL;

  scrambler_64b u_scr (
    .state_i (scr_st_q),
    .data_i  (blk_data),
    .state_o (scr_st_nxt),
    .data_o  (scr_out)
  );

  always_comb begin
    scr_st_d = scr_st_q;
    word_d   = word_q;
    hi_d     = hi_q;
    hdr_d    = hdr_q;
    txseq_d  = txseq_q;
    und_d    = und_q;
    if (phase_q == PH_LO) begin
      txseq_d = {1'b0, seq_q};
      if (load) begin
        word_d = scr_bypass_i ? blk_data[31:0]  : scr_out[31:0];
        hi_d   = scr_bypass_i ? blk_data[63:32] : scr_out[63:32];
        hdr_d  = blk_hdr;
        if (!scr_bypass_i) begin
          scr_st_d = scr_st_nxt;
        end
        if (!tx_if.tx_valid_i && (und_q != '1)) begin
          und_d = und_q + UND_ONE;
        end
      end
    end else if (!pause) begin
      word_d = hi_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      scr_st_q <= SCR_SEED;
      word_q   <= '0;
      hi_q     <= '0;
      hdr_q    <= HDR_CTRL;
      txseq_q  <= '0;
      und_q    <= '0;
    end else begin
      scr_st_q <= scr_st_d;
      word_q   <= word_d;
      hi_q     <= hi_d;
      hdr_q    <= hdr_d;
      txseq_q  <= txseq_d;
      und_q    <= und_d;
    end
  end

  assign gtwiz_userdata_tx_o = word_q;
  assign txheader_o          = hdr_q;
  assign txsequence_o        = txseq_q;
  assign underrun_o          = und_q;

endmodule
